// File: rtl/key_pkg.sv
// Shared types and helpers for the key code decoder.
//   key_dec_state_t : decoder FSM states
//   KEY_NUM         : number of keys (decimal digits 0..9)
//   KEY_CODE_W      : width of a BCD key code
//   is_valid_key()  : a sample is a key only when gs=1 and the code is 0..9
package key_pkg;

  localparam int unsigned KEY_NUM    = 10;
  localparam int unsigned KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    PRESSED,
    RELEASE_DB
  } key_dec_state_t;

  function automatic logic is_valid_key(input logic gs, input logic [KEY_CODE_W-1:0] code);
    return gs && (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_onehot_dec.sv
// Combinational inverse of the keyboard encoder: 4-bit code to active-low one-hot.
//   code_i  : BCD key code
//   valid_i : 1 when code_i names a held key
//   d_n_o   : active-low one-hot image, all ones when valid_i=0 or code_i>9
module key_onehot_dec
  import key_pkg::*;
(
  input  logic [KEY_CODE_W-1:0] code_i,
  input  logic                  valid_i,
  output logic [KEY_NUM-1:0]    d_n_o
);

  always_comb begin
    d_n_o = '1;
    for (int unsigned i = 0; i < KEY_NUM; i++) begin
      if (valid_i && (code_i == KEY_CODE_W'(i))) begin
        d_n_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_code_decoder.sv
// Debouncing receiver for the 10-key keyboard encoder.
//   clk, rst      : clock and synchronous active-high reset
//   L, GS         : encoder key code and "key pressed" flag
//   D_n           : active-low one-hot of the held key (all ones when none)
//   key_code      : held key code, 0 when none
//   key_valid     : 1 while a debounced key is held
//   press_pulse   : one-cycle pulse when a press is accepted
//   release_pulse : one-cycle pulse when a release is accepted
//   err           : one-cycle pulse after sampling GS=1 with L>9
module key_code_decoder
  import key_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_CODE_W-1:0] L,
  input  logic                  GS,
  output logic [KEY_NUM-1:0]    D_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic                  err
);

  localparam logic [CNT_W-1:0] DbMax = CNT_W'(DEBOUNCE_CYCLES);

  logic                  s_gs_q;
  logic [KEY_CODE_W-1:0] s_code_q;

  key_dec_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  cand_vld_q, cand_vld_d;
  logic [KEY_CODE_W-1:0] cand_code_q, cand_code_d;

  logic                  smp_vld;
  logic [KEY_CODE_W-1:0] smp_code;
  logic                  smp_is_held, smp_is_cand, cnt_last;
  logic                  press_acc, release_acc;
  logic [KEY_CODE_W-1:0] press_code;
  logic [KEY_NUM-1:0]    onehot_n;

  logic [KEY_NUM-1:0]    d_n_q, d_n_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  press_q, press_d, release_q, release_d, err_q, err_d;

  // "None" samples carry code 0 so a single compare matches both kind and code.
  assign smp_vld     = is_valid_key(s_gs_q, s_code_q);
  assign smp_code    = smp_vld ? s_code_q : '0;
  assign smp_is_held = smp_vld && (smp_code == key_code_q);
  assign smp_is_cand = (smp_vld == cand_vld_q) && (smp_code == cand_code_q);
  // cnt_q counts matching samples before this edge; accept on the DEBOUNCE_CYCLES-th.
  assign cnt_inc     = cnt_q + 1'b1;
  assign cnt_last    = (cnt_inc == DbMax);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      s_gs_q      <= 1'b0;
      s_code_q    <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_vld_q  <= 1'b0;
      cand_code_q <= '0;
      d_n_q       <= '1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s_gs_q      <= GS;
      s_code_q    <= L;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_vld_q  <= cand_vld_d;
      cand_code_q <= cand_code_d;
      d_n_q       <= d_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      press_q     <= press_d;
      release_q   <= release_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_vld_d  = cand_vld_q;
    cand_code_d = cand_code_q;
    press_acc   = 1'b0;
    release_acc = 1'b0;
    press_code  = cand_code_q;
    unique case (state_q)
      IDLE: begin
        if (smp_vld) begin
          if (DEBOUNCE_CYCLES == 1) begin
            press_acc  = 1'b1;
            press_code = smp_code;
            state_d    = PRESSED;
            cnt_d      = '0;
          end else begin
            state_d     = PRESS_DB;
            cand_vld_d  = 1'b1;
            cand_code_d = smp_code;
            cnt_d       = CNT_W'(1);
          end
        end
      end
      PRESS_DB: begin
        if (!smp_vld) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!smp_is_cand) begin
          cand_vld_d  = 1'b1;
          cand_code_d = smp_code;
          cnt_d       = CNT_W'(1);
        end else if (cnt_last) begin
          press_acc = 1'b1;
          state_d   = PRESSED;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!smp_is_held) begin
          if (DEBOUNCE_CYCLES == 1) begin
            release_acc = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
          end else begin
            state_d     = RELEASE_DB;
            cand_vld_d  = smp_vld;
            cand_code_d = smp_code;
            cnt_d       = CNT_W'(1);
          end
        end
      end
      RELEASE_DB: begin
        if (smp_is_held) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (smp_is_cand) begin
          if (cnt_last) begin
            // A valid candidate must still debounce from IDLE; no direct handoff.
            release_acc = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cand_vld_d  = smp_vld;
          cand_code_d = smp_code;
          cnt_d       = CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  key_onehot_dec u_onehot (
    .code_i  (press_code),
    .valid_i (press_acc),
    .d_n_o   (onehot_n)
  );

  // Output logic: held-key outputs move together, only on accepting edges.
  always_comb begin
    d_n_d       = d_n_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    press_d     = press_acc;
    release_d   = release_acc;
    err_d       = s_gs_q && (s_code_q > 4'd9);
    if (press_acc) begin
      d_n_d       = onehot_n;
      key_code_d  = press_code;
      key_valid_d = 1'b1;
    end else if (release_acc) begin
      d_n_d       = '1;
      key_code_d  = '0;
      key_valid_d = 1'b0;
    end
  end

  assign D_n           = d_n_q;
  assign key_code      = key_code_q;
  assign key_valid     = key_valid_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign err           = err_q;

endmodule
